// File: rtl/phy_pkg.sv
// Shared PHY lane definitions: comma symbol, byte width and serializer states.
// Also used by the serial-to-parallel receiver.
package phy_pkg;

  localparam logic [7:0]  COMMA_SYM = 8'hBC;
  localparam int unsigned BYTE_W    = 8;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Saturating 16-bit increment.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/ps_shift8.sv
// 8-bit MSB-first load/shift register with its 3-bit bit counter.
// The counter resets to 7 so the first edge after reset is a load edge.
module ps_shift8
  import phy_pkg::*;
(
  input  logic              clk_32f,
  input  logic              reset,
  input  logic [BYTE_W-1:0] i_next_byte,
  output logic              o_msb,
  output logic              o_last_bit
);

  logic [BYTE_W-1:0] r_sr;
  logic [2:0]        r_bit_cnt;
  logic              w_last_bit;

  assign w_last_bit = (r_bit_cnt == 3'd7);

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_sr      <= '0;
      r_bit_cnt <= 3'd7;
    end else if (w_last_bit) begin
      r_sr      <= i_next_byte;
      r_bit_cnt <= 3'd0;
    end else begin
      r_sr      <= {r_sr[BYTE_W-2:0], 1'b0};
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  assign o_msb      = r_sr[BYTE_W-1];
  assign o_last_bit = w_last_bit;

endmodule

// File: rtl/parallel_serial_tx.sv
// PHY lane serializer: sends SYNC_COMMAS commas after reset, then one byte per 8 clk_32f
// cycles MSB-first, filling idle slots with COMMA. Define PARALLEL_SERIAL_TX_BYTE_COUNT_EN
// to add a saturating count of transmitted data bytes.
module parallel_serial_tx
  import phy_pkg::*;
#(
  parameter logic [7:0]  COMMA       = COMMA_SYM,
  parameter int unsigned SYNC_COMMAS = 4,
  parameter int unsigned DATA_W      = BYTE_W
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              data_out,
  output logic              ready,
  output logic              active
`ifdef PARALLEL_SERIAL_TX_BYTE_COUNT_EN
  ,
  output logic [15:0]       byte_count
`endif
);

  if (DATA_W != BYTE_W) begin : g_bad_data_w
    $error("parallel_serial_tx: DATA_W must be 8");
  end
  if (SYNC_COMMAS < 1 || SYNC_COMMAS > 15) begin : g_bad_sync_commas
    $error("parallel_serial_tx: SYNC_COMMAS must be in 1..15");
  end

  localparam logic [3:0] LAST_COMMA = 4'(SYNC_COMMAS - 1);

  state_e            r_state;
  state_e            w_state_d;
  logic [3:0]        r_comma_cnt;
  logic [3:0]        w_comma_cnt_d;
  logic [BYTE_W-1:0] w_next_byte;
  logic              w_last_bit;
  logic              w_msb;

  ps_shift8 u_shift (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .i_next_byte (w_next_byte),
    .o_msb       (w_msb),
    .o_last_bit  (w_last_bit)
  );

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_state     <= SYNC;
      r_comma_cnt <= 4'd0;
    end else begin
      r_state     <= w_state_d;
      r_comma_cnt <= w_comma_cnt_d;
    end
  end

  // Next byte is only consumed by the shifter on a last-bit edge.
  always_comb begin
    w_state_d     = r_state;
    w_comma_cnt_d = r_comma_cnt;
    w_next_byte   = COMMA;
    case (r_state)
      SYNC: begin
        if (w_last_bit) begin
          w_comma_cnt_d = r_comma_cnt + 4'd1;
          if (r_comma_cnt == LAST_COMMA) begin
            w_state_d = RUN;
          end
        end
      end
      RUN: begin
        if (valid_in) begin
          w_next_byte = data_in;
        end
      end
      default: begin
        w_state_d = SYNC;
      end
    endcase
  end

  assign data_out = w_msb;
  assign active   = (r_state == RUN);
  assign ready    = (r_state == RUN) && w_last_bit;

`ifdef PARALLEL_SERIAL_TX_BYTE_COUNT_EN
  logic [15:0] r_byte_count;

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_byte_count <= 16'd0;
    end else if (ready && valid_in) begin
      r_byte_count <= sat_inc16(r_byte_count);
    end
  end

  assign byte_count = r_byte_count;
`endif

endmodule

// File: tb/tb_parallel_serial_tx.sv
// Directed self-checking bench for parallel_serial_tx: sync commas, data, idle fill,
// mid-byte input changes, async reset, and the optional byte counter.
module tb_parallel_serial_tx;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       data_out;
  logic       ready;
  logic       active;
`ifdef PARALLEL_SERIAL_TX_BYTE_COUNT_EN
  logic [15:0] byte_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_32f = ~clk_32f;

  parallel_serial_tx #(
    .COMMA       (8'hBC),
    .SYNC_COMMAS (4),
    .DATA_W      (8)
  ) dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out   (data_out),
    .ready      (ready),
    .active     (active)
`ifdef PARALLEL_SERIAL_TX_BYTE_COUNT_EN
    ,
    .byte_count (byte_count)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: active edge, then sample point on the falling edge.
  task automatic tick();
    @(posedge clk_32f);
    @(negedge clk_32f);
  endtask

  // Called right after reset release; ends in the first ready cycle.
  task automatic sync_check();
    logic [7:0] c;
    c = 8'hBC;
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("sync_bit", 16'(data_out), 16'(c[7 - (i % 8)]));
      chk("sync_active", 16'(active), 16'(i >= 24));
      chk("sync_ready", 16'(ready), 16'(i == 31));
    end
  endtask

  // Called in a ready cycle; ends in the next ready cycle.
  task automatic send_byte(input logic v, input logic [7:0] d, input logic [7:0] exp,
                           input bit garble);
    logic [7:0] rx;
    rx = 8'h00;
    chk("ready_at_load", 16'(ready), 16'd1);
    valid_in = v;
    data_in  = d;
    for (int j = 0; j < 8; j++) begin
      tick();
      rx = {rx[6:0], data_out};
      chk("ser_bit", 16'(data_out), 16'(exp[7 - j]));
      chk("ready_bit", 16'(ready), 16'(j == 7));
      if (garble && j < 7) begin
        data_in  = 8'($urandom);
        valid_in = 1'($urandom);
      end
    end
    chk("loopback_byte", 16'(rx), 16'(exp));
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    repeat (3) @(negedge clk_32f);
    chk("rst_data_out", 16'(data_out), 16'd0);
    chk("rst_ready", 16'(ready), 16'd0);
    chk("rst_active", 16'(active), 16'd0);
    reset = 1'b0;

    sync_check();

    // Data bytes back-to-back.
    send_byte(1'b1, 8'hAA, 8'hAA, 1'b0);
    send_byte(1'b1, 8'hBB, 8'hBB, 1'b0);
    send_byte(1'b1, 8'hCC, 8'hCC, 1'b0);
    send_byte(1'b1, 8'hDD, 8'hDD, 1'b0);
    send_byte(1'b1, 8'hEE, 8'hEE, 1'b0);
    send_byte(1'b1, 8'hFF, 8'hFF, 1'b0);
    send_byte(1'b1, 8'h00, 8'h00, 1'b0);

    // Idle slots get comma fill, data_in ignored.
    send_byte(1'b1, 8'h5A, 8'h5A, 1'b0);
    send_byte(1'b0, 8'h12, 8'hBC, 1'b0);
    send_byte(1'b0, 8'h34, 8'hBC, 1'b0);
    send_byte(1'b0, 8'h56, 8'hBC, 1'b0);
    send_byte(1'b1, 8'hA5, 8'hA5, 1'b0);

    // Inputs scrambled between load edges.
    send_byte(1'b1, 8'h3C, 8'h3C, 1'b1);
    chk("active_run", 16'(active), 16'd1);
`ifdef PARALLEL_SERIAL_TX_BYTE_COUNT_EN
    chk("byte_count_run", byte_count, 16'd10);
`endif

    // Async reset partway through a data byte.
    valid_in = 1'b1;
    data_in  = 8'h69;
    repeat (4) tick();
    valid_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_data_out", 16'(data_out), 16'd0);
    chk("async_rst_active", 16'(active), 16'd0);
    chk("async_rst_ready", 16'(ready), 16'd0);
    repeat (2) @(negedge clk_32f);
    reset = 1'b0;
`ifdef PARALLEL_SERIAL_TX_BYTE_COUNT_EN
    chk("byte_count_rst", byte_count, 16'd0);
`endif

    sync_check();

    send_byte(1'b1, 8'h11, 8'h11, 1'b0);
    send_byte(1'b0, 8'h77, 8'hBC, 1'b0);
    send_byte(1'b1, 8'h22, 8'h22, 1'b0);
    send_byte(1'b1, 8'hBC, 8'hBC, 1'b0);
    send_byte(1'b0, 8'h88, 8'hBC, 1'b0);
    send_byte(1'b1, 8'h44, 8'h44, 1'b0);
    send_byte(1'b1, 8'h55, 8'h55, 1'b0);
`ifdef PARALLEL_SERIAL_TX_BYTE_COUNT_EN
    chk("byte_count_five", byte_count, 16'd5);
    force dut.r_byte_count = 16'hFFFE;
    #1 release dut.r_byte_count;
    send_byte(1'b1, 8'h01, 8'h01, 1'b0);
    chk("byte_count_max", byte_count, 16'hFFFF);
    send_byte(1'b1, 8'h02, 8'h02, 1'b0);
    send_byte(1'b1, 8'h03, 8'h03, 1'b0);
    chk("byte_count_sat", byte_count, 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
